// File: rtl/sd_pkg.sv
// Shared types and helpers for the sd_elastic_buf family of valid/ready buffers.
package sd_pkg;

    typedef enum logic [0:0] {
        SD_BUF_REG = 1'b0,
        SD_BUF_FT  = 1'b1
    } sd_buf_mode_e;

    localparam int unsigned SD_DEPTH_MIN = 2;
    localparam int unsigned SD_DEPTH_MAX = 64;

    // Wrap explicitly so non-power-of-2 depths work.
    function automatic int unsigned sd_ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sd_buf_ptr.sv
// Wrapping circular-buffer pointer with increment and synchronous clear.
module sd_buf_ptr
    import sd_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = PW'(sd_ptr_inc(32'(ptr_q), DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sd_elastic_buf.sv
// N-entry elastic buffer on a valid/ready link, registered or fall-through output.
// Optional high-water-mark output enabled by defining SD_ELASTIC_BUF_HWM_EN.
module sd_elastic_buf
    import sd_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MODE         = 0,
    parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       s_valid,
    input  logic [WIDTH-1:0]           s_data,
    output logic                       s_ready,
    output logic                       d_valid,
    output logic [WIDTH-1:0]           d_data,
    input  logic                       d_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       afull
`ifdef SD_ELASTIC_BUF_HWM_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] hwm
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam bit FALL_THROUGH = (MODE == 32'(SD_BUF_FT));

    if (DEPTH < SD_DEPTH_MIN || DEPTH > SD_DEPTH_MAX || MODE > 1 ||
        AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_param
        $fatal(1, "sd_elastic_buf: illegal parameter combination");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rff_wr_ptr, rff_rd_ptr;
    logic [CW-1:0]    rff_count, count_d;
    logic             empty, full, active, bypass, push, pop, wr_en, rd_en, clr;

    always_comb begin
        clr     = rst | flush;
        active  = ~clr;
        empty   = (rff_count == '0);
        full    = (rff_count == CW'(DEPTH));
        s_ready = ~full & active;
        // Fall-through: an empty buffer presents the source beat directly.
        bypass  = FALL_THROUGH & empty & s_valid & active;
        d_valid = (~empty & active) | bypass;
        // Showing s_data while empty keeps d_data free of unwritten storage.
        d_data  = empty ? s_data : mem[rff_rd_ptr];
        push    = s_valid & s_ready;
        pop     = d_valid & d_ready;
        wr_en   = push & ~(bypass & d_ready);
        rd_en   = pop & ~empty;
        count_d = clr ? '0 : rff_count + CW'(wr_en) - CW'(rd_en);
        count   = rst ? '0 : rff_count;
        afull   = ~rst & (32'(rff_count) >= AFULL_THRESH);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[rff_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rff_count <= '0;
        end else begin
            rff_count <= count_d;
        end
    end

    sd_buf_ptr #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (wr_en),
        .ptr (rff_wr_ptr)
    );

    sd_buf_ptr #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (rd_en),
        .ptr (rff_rd_ptr)
    );

`ifdef SD_ELASTIC_BUF_HWM_EN
    logic [CW-1:0] hwm_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            hwm_q <= '0;
        end else if (count_d > hwm_q) begin
            hwm_q <= count_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_sd_elastic_buf.sv
// Randomised and directed bench for sd_elastic_buf against a queue-based reference model.
module tb_sd_elastic_buf;

    logic       clk = 1'b0;
    logic       rst, flush, s_valid, d_ready;
    logic [7:0] s_data;

    logic       sr_a, dv_a, af_a, sr_b, dv_b, af_b, sr_c, dv_c, af_c;
    logic [7:0] dd_a, dd_b, dd_c;
    logic [2:0] cnt_a;
    logic [1:0] cnt_b, cnt_c;
`ifdef SD_ELASTIC_BUF_HWM_EN
    logic [2:0] hwm_a;
    logic [1:0] hwm_b, hwm_c;
`endif

    always #5 clk = ~clk;

    sd_elastic_buf #(.WIDTH(8), .DEPTH(4), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_data(s_data),
        .s_ready(sr_a), .d_valid(dv_a), .d_data(dd_a), .d_ready(d_ready),
        .count(cnt_a), .afull(af_a)
`ifdef SD_ELASTIC_BUF_HWM_EN
        , .hwm(hwm_a)
`endif
    );

    sd_elastic_buf #(.WIDTH(8), .DEPTH(3), .MODE(0)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_data(s_data),
        .s_ready(sr_b), .d_valid(dv_b), .d_data(dd_b), .d_ready(d_ready),
        .count(cnt_b), .afull(af_b)
`ifdef SD_ELASTIC_BUF_HWM_EN
        , .hwm(hwm_b)
`endif
    );

    sd_elastic_buf #(.WIDTH(8), .DEPTH(2), .MODE(1), .AFULL_THRESH(1)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_data(s_data),
        .s_ready(sr_c), .d_valid(dv_c), .d_data(dd_c), .d_ready(d_ready),
        .count(cnt_c), .afull(af_c)
`ifdef SD_ELASTIC_BUF_HWM_EN
        , .hwm(hwm_c)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one queue per instance plus its configuration.
    int         dep  [3] = '{4, 3, 2};
    int         mode [3] = '{0, 0, 1};
    int         thr  [3] = '{3, 2, 1};
    logic [7:0] mq   [3][$];
    int         mhwm [3] = '{0, 0, 0};
    logic [7:0] outq_a[$];
    logic [7:0] outq_b[$];

    initial begin
        int  a_sr[3], a_dv[3], a_dd[3], a_cnt[3], a_af[3], a_hwm[3];
        int  n, e_sr, e_dv, e_ft, e_cnt, e_af, e_dd, got;
        @(posedge clk);
        forever begin
            @(negedge clk);
            a_sr  = '{int'(sr_a), int'(sr_b), int'(sr_c)};
            a_dv  = '{int'(dv_a), int'(dv_b), int'(dv_c)};
            a_dd  = '{int'(dd_a), int'(dd_b), int'(dd_c)};
            a_cnt = '{int'(cnt_a), int'(cnt_b), int'(cnt_c)};
            a_af  = '{int'(af_a), int'(af_b), int'(af_c)};
`ifdef SD_ELASTIC_BUF_HWM_EN
            a_hwm = '{int'(hwm_a), int'(hwm_b), int'(hwm_c)};
`else
            a_hwm = '{0, 0, 0};
`endif
            for (int i = 0; i < 3; i++) begin
                n = mq[i].size();
                e_ft = 0;
                e_dd = 0;
                if (rst) begin
                    e_sr = 0; e_dv = 0; e_cnt = 0; e_af = 0;
                end else begin
                    e_cnt = n;
                    e_af  = (n >= thr[i]) ? 1 : 0;
                    if (flush) begin
                        e_sr = 0; e_dv = 0;
                    end else begin
                        e_sr = (n < dep[i]) ? 1 : 0;
                        e_ft = (mode[i] == 1 && n == 0 && s_valid) ? 1 : 0;
                        e_dv = (n > 0 || e_ft == 1) ? 1 : 0;
                        e_dd = (n > 0) ? int'(mq[i][0]) : int'(s_data);
                    end
                end
                chk($sformatf("dut%0d s_ready", i), a_sr[i], e_sr);
                chk($sformatf("dut%0d d_valid", i), a_dv[i], e_dv);
                chk($sformatf("dut%0d count", i), a_cnt[i], e_cnt);
                chk($sformatf("dut%0d afull", i), a_af[i], e_af);
                if (e_dv == 1) chk($sformatf("dut%0d d_data", i), a_dd[i], e_dd);
`ifdef SD_ELASTIC_BUF_HWM_EN
                chk($sformatf("dut%0d hwm", i), a_hwm[i], mhwm[i]);
`endif
                if (rst || flush) begin
                    mq[i].delete();
                    mhwm[i] = 0;
                end else begin
                    if (e_dv == 1 && d_ready) begin
                        got = (n > 0) ? int'(mq[i].pop_front()) : int'(s_data);
                        if (i == 0) outq_a.push_back(8'(got));
                        if (i == 1) outq_b.push_back(8'(got));
                    end
                    if (s_valid && e_sr == 1 && !(e_ft == 1 && d_ready)) mq[i].push_back(s_data);
                    if (mq[i].size() > mhwm[i]) mhwm[i] = mq[i].size();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            step();
        end
    endtask

    logic [7:0] fill_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; d_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset s_ready", int'(sr_a), 1);
        chk("reset count", int'(cnt_a), 0);
        chk("reset d_valid", int'(dv_a), 0);
        chk("reset afull", int'(af_a), 0);
        step();

        // Fill and drain on the depth-4 registered instance.
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = fill_d[i];
            @(negedge clk);
            chk("fill s_ready", int'(sr_a), 1);
            step();
        end
        s_data = 8'h55;
        @(negedge clk);
        chk("full s_ready", int'(sr_a), 0);
        chk("full count", int'(cnt_a), 4);
        chk("full afull", int'(af_a), 1);
        step();
        s_valid = 1'b0; d_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain d_valid", int'(dv_a), 1);
            chk("drain d_data", int'(dd_a), int'(fill_d[i]));
            step();
        end
        @(negedge clk);
        chk("drained count", int'(cnt_a), 0);
        step();

        // Streaming through the depth-3 instance.
        outq_a.delete(); outq_b.delete();
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = 8'(i);
            @(negedge clk);
            if (i == 5) chk("stream count", int'(cnt_b), 1);
            step();
        end
        s_valid = 1'b0;
        idle(3);
        chk("stream length", outq_b.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < outq_b.size()) chk("stream order", int'(outq_b[i]), i);
        end

        // Fall-through on the empty mode-1 instance.
        s_valid = 1'b1; s_data = 8'hA5; d_ready = 1'b1;
        @(negedge clk);
        chk("ft d_valid", int'(dv_c), 1);
        chk("ft d_data", int'(dd_c), 8'hA5);
        step();
        s_valid = 1'b0;
        @(negedge clk);
        chk("ft count", int'(cnt_c), 0);
        step();
        idle(2);

        // Depth-2 full with simultaneous pop.
        d_ready = 1'b0; s_valid = 1'b1;
        s_data = 8'h31; idle(1);
        s_data = 8'h32; idle(1);
        s_data = 8'h33; d_ready = 1'b1;
        @(negedge clk);
        chk("fullpop s_ready", int'(sr_c), 0);
        chk("fullpop d_data", int'(dd_c), 8'h31);
        step();
        s_valid = 1'b0; d_ready = 1'b0;
        @(negedge clk);
        chk("fullpop next s_ready", int'(sr_c), 1);
        chk("fullpop next count", int'(cnt_c), 1);
        step();
        d_ready = 1'b1;
        idle(4);

        // Flush with three entries held.
        d_ready = 1'b0; s_valid = 1'b1;
        s_data = 8'h41; idle(1);
        s_data = 8'h42; idle(1);
        s_data = 8'h43; idle(1);
        flush = 1'b1; s_data = 8'h77;
        @(negedge clk);
        chk("flush pre count", int'(cnt_a), 3);
        chk("flush d_valid", int'(dv_a), 0);
        chk("flush s_ready", int'(sr_a), 0);
        step();
        flush = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("flush count", int'(cnt_a), 0);
        chk("flush no store", int'(dv_a), 0);
        step();

        // Reset with two entries held.
        s_valid = 1'b1;
        s_data = 8'h51; idle(1);
        s_data = 8'h52; idle(1);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst d_valid", int'(dv_a), 0);
            chk("rst s_ready", int'(sr_a), 0);
            step();
        end
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("rst release count", int'(cnt_a), 0);
        chk("rst release s_ready", int'(sr_a), 1);
`ifdef SD_ELASTIC_BUF_HWM_EN
        chk("rst release hwm", int'(hwm_a), 0);
`endif
        step();

        // Random traffic, first biased towards filling, then towards draining.
        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom_range(0, 99) < 70);
            d_ready = ($urandom_range(0, 99) < ((i < 1500) ? 35 : 80));
            s_data  = 8'($urandom);
            flush   = ($urandom_range(0, 59) == 0);
            rst     = ($urandom_range(0, 249) == 0);
            idle(1);
        end
        rst = 1'b0; flush = 1'b0; s_valid = 1'b0; d_ready = 1'b1;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
